i2c_rx_fifo: RTL

//  Receive-data FIFO between the I2C byte shifter and the APB read mux.

---
 rtl/i2c_rx_fifo_pkg.sv | 18 +
 rtl/i2c_rx_fifo_if.sv | 29 ++
 rtl/i2c_rx_fifo_mem.sv | 24 ++
 rtl/i2c_rx_fifo.sv | 107 ++++++++++
 4 files changed

// File: rtl/i2c_rx_fifo_pkg.sv
// Shared constants for the I2C receive FIFO: geometry, status bit positions
// and the data-mux address that pops the FIFO.
package i2c_rx_fifo_pkg;

  localparam int RX_FIFO_DEPTH = 8;
  localparam int RX_FIFO_AW    = 3;
  localparam int RX_DATA_W     = 8;

  localparam int ST_RXEMPTY = 0;
  localparam int ST_RXFULL  = 1;
  localparam int ST_RXOVF   = 2;
  localparam int ST_RXTHR   = 3;

  localparam logic [7:0] DM_CTRL   = 8'h00;
  localparam logic [7:0] DM_STATUS = 8'h04;
  localparam logic [7:0] DM_RXDATA = 8'h08;

endpackage

// File: rtl/i2c_rx_fifo_if.sv
// Bundle between the byte shifter / APB decode (master) and the receive
// FIFO (slave).
interface i2c_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wrEn;
  logic [DATA_W-1:0] wrData;
  logic              rdEn;
  logic              flush;
  logic              ovfClr;
  logic [ADDR_W:0]   thresh;
  logic [DATA_W-1:0] rxData;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              thrIrq;

  modport master (
    output wrEn, wrData, rdEn, flush, ovfClr, thresh,
    input  rxData, empty, full, level, overflow, thrIrq
  );

  modport slave (
    input  wrEn, wrData, rdEn, flush, ovfClr, thresh,
    output rxData, empty, full, level, overflow, thrIrq
  );
endinterface

// File: rtl/i2c_rx_fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module i2c_rx_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/i2c_rx_fifo.sv
// Show-ahead receive FIFO with explicit level, sticky overflow and flush.
// Optional threshold interrupt enabled by defining I2C_RX_FIFO_THRESH_EN.
module i2c_rx_fifo
  import i2c_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_AW,
  parameter int DATA_W = RX_DATA_W
) (
  input  logic          pclk,
  input  logic          reset,
  i2c_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              empty_s, full_s, push, pop, drop;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    empty_s = (level_q == '0);
    full_s  = (level_q == LVL_FULL);
    // A pop frees the slot the simultaneous push needs, so full+rdEn still accepts.
    push = bus.wrEn && (!full_s || bus.rdEn) && !bus.flush;
    pop  = bus.rdEn && !empty_s && !bus.flush;
    drop = bus.wrEn && full_s && !bus.rdEn;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop)            overflow_d = 1'b1;
      else if (bus.ovfClr) overflow_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  i2c_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (pclk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.wrData),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

`ifdef I2C_RX_FIFO_THRESH_EN
  logic thr_irq_q, thr_irq_d;

  always_comb begin
    thr_irq_d = !bus.flush && (bus.thresh != '0) && (level_d >= bus.thresh);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) thr_irq_q <= 1'b0;
    else       thr_irq_q <= thr_irq_d;
  end

  assign bus.thrIrq = thr_irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^bus.thresh;
  assign bus.thrIrq    = 1'b0;
`endif

  assign bus.rxData   = empty_s ? '0 : rd_data;
  assign bus.empty    = empty_s;
  assign bus.full     = full_s;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;

endmodule
